// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive side of a VGA link. Samples HS/VS/RGB on pixel-strobe
// clocks and recovers the pixel position from the sync falling edges alone.
// It checks line and frame lengths and declares lock after LOCK_FRAMES
// consecutive good frames.
//
// Optional build macro: FRAME_CRC_EN. When it is defined, the block computes
// a per-frame CRC-16-CCITT over valid pixels. When it is undefined, o_crc is
// tied to zero.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous, active-low reset
//   i_pix_stb    pixel strobe; all sampling and counting happens only here
//   i_hs, i_vs   active-low sync inputs
//   i_rgb        pixel data {R[2:0],G[2:0],B[1:0]}
//   o_x, o_y     active-area column/line (hold outside the active area)
//   o_de         pixel valid (locked and inside the active area)
//   o_pix        registered i_rgb when o_de, else 0
//   o_locked     timing lock
//   o_frame_stb  1-clk pulse at each VS fall while locked
//   o_err        1-clk pulse on any timing violation
//   o_crc        last completed frame CRC (0 when FRAME_CRC_EN is undefined)
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic [7:0]  i_rgb,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_de,
  output logic [7:0]  o_pix,
  output logic        o_locked,
  output logic        o_frame_stb,
  output logic        o_err,
  output logic [15:0] o_crc
);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [11:0] H_LEN   = 12'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
  localparam logic [10:0] H_STUCK = 11'(2 * H_TOTAL);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  state_t      state_reg, state_next;
  logic [10:0] h_cnt_reg, h_cnt_next;
  logic [9:0]  v_cnt_reg, v_cnt_next;
  logic        vs_pend_reg, vs_pend_next;
  logic        hs_q_reg, vs_q_reg;
  logic        h_arm_reg, h_arm_next;
  logic [2:0]  good_reg, good_next;
  logic        hs_fall, vs_fall, h_bad, v_bad, stuck, fail;
  logic        frame_next, active, de_next;

  // Position counters. A VS fall only arms vs_pend; the next HS fall
  // (possibly on the same strobe) consumes it and restarts the line count.
  always_comb begin
    hs_fall      = i_pix_stb & hs_q_reg & ~i_hs;
    vs_fall      = i_pix_stb & vs_q_reg & ~i_vs;
    h_cnt_next   = h_cnt_reg;
    v_cnt_next   = v_cnt_reg;
    vs_pend_next = vs_pend_reg;
    if (i_pix_stb) begin
      if (hs_fall)
        h_cnt_next = '0;
      else if (h_cnt_reg != 11'h7FF)
        h_cnt_next = h_cnt_reg + 11'd1;

      if (hs_fall) begin
        vs_pend_next = 1'b0;
        if (vs_pend_reg || vs_fall)
          v_cnt_next = '0;
        else if (v_cnt_reg != 10'h3FF)
          v_cnt_next = v_cnt_reg + 10'd1;
      end else if (vs_fall) begin
        vs_pend_next = 1'b1;
      end
    end
  end

  // Lock FSM. h_arm keeps the line-length check off until an HS fall has
  // restarted h_cnt after entering TRACK.
  always_comb begin
    h_bad      = hs_fall & h_arm_reg & (({1'b0, h_cnt_reg} + 12'd1) != H_LEN);
    v_bad      = vs_fall & (({1'b0, v_cnt_reg} + 11'd1) != V_LEN);
    stuck      = i_pix_stb & (h_cnt_next == H_STUCK);
    fail       = (state_reg != SEARCH) & (h_bad | v_bad | stuck);
    state_next = state_reg;
    good_next  = good_reg;
    h_arm_next = h_arm_reg | hs_fall;
    frame_next = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (vs_fall) begin
          state_next = TRACK;
          good_next  = '0;
          h_arm_next = hs_fall;
        end
      end
      TRACK: begin
        if (fail) begin
          state_next = SEARCH;
          good_next  = '0;
        end else if (vs_fall) begin
          good_next = good_reg + 3'd1;
          if (good_next == LOCK_N)
            state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (fail) begin
          state_next = SEARCH;
          good_next  = '0;
        end else if (vs_fall) begin
          frame_next = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase

    active  = (h_cnt_next >= H_START) && (h_cnt_next < H_END) &&
              (v_cnt_next >= V_START) && (v_cnt_next < V_END);
    // Uses the post-update state so the strobe that loses lock is not valid.
    de_next = i_pix_stb & (state_next == LOCKED) & active;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg   <= SEARCH;
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      vs_pend_reg <= 1'b0;
      hs_q_reg    <= 1'b1;
      vs_q_reg    <= 1'b1;
      h_arm_reg   <= 1'b0;
      good_reg    <= '0;
      o_x         <= '0;
      o_y         <= '0;
      o_de        <= 1'b0;
      o_pix       <= '0;
      o_locked    <= 1'b0;
      o_frame_stb <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_err       <= 1'b0;
      o_frame_stb <= 1'b0;
      if (i_pix_stb) begin
        state_reg   <= state_next;
        h_cnt_reg   <= h_cnt_next;
        v_cnt_reg   <= v_cnt_next;
        vs_pend_reg <= vs_pend_next;
        hs_q_reg    <= i_hs;
        vs_q_reg    <= i_vs;
        h_arm_reg   <= h_arm_next;
        good_reg    <= good_next;
        o_err       <= fail;
        o_frame_stb <= frame_next;
        o_de        <= de_next;
        o_pix       <= de_next ? i_rgb : 8'h00;
        o_locked    <= (state_next == LOCKED);
        if (active) begin
          o_x <= 10'(h_cnt_next - H_START);
          o_y <= 9'(v_cnt_next - V_START);
        end
      end
    end
  end

`ifdef FRAME_CRC_EN
  logic [15:0] crc_run_reg;
  logic [15:0] crc_base;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  // The running CRC restarts on lock entry and after each latched frame.
  always_comb begin
    crc_base = crc_run_reg;
    if ((state_next == LOCKED && state_reg != LOCKED) || frame_next)
      crc_base = 16'hFFFF;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      crc_run_reg <= 16'hFFFF;
      o_crc       <= '0;
    end else if (i_pix_stb) begin
      if (frame_next)
        o_crc <= crc_run_reg;
      crc_run_reg <= de_next ? crc16_byte(crc_base, i_rgb) : crc_base;
    end
  end
`else
  assign o_crc = 16'h0000;
`endif

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
Receive side of the 640x480 VGA link. Samples HS/VS and 8-bit RGB at pixel-strobe rate and recovers the pixel position from the sync edges alone. Validates line and frame timing, and declares lock after consecutive good frames. Sits behind a loopback or capture path and feeds frame-checker and capture logic with o_x/o_y/o_de/o_pix.

Parameters:
H_TOTAL, 800, pixels per line
H_SYNC, 96, HS pulse width in pixels
H_BP, 48, back porch in pixels
H_ACTIVE, 640, visible pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, VS pulse width in lines
V_BP, 33, back porch in lines
V_ACTIVE, 480, visible lines
LOCK_FRAMES, 2, consecutive good frames required for lock (1..7)

Ports:
i_clk  in  1  system clock, 100 MHz
i_rst  in  1  synchronous, active-low reset
i_pix_stb  in  1  pixel strobe, 1 clk wide, 25 MHz; all sampling and counting happens only on clocks where this is 1
i_hs  in  1  horizontal sync, active-low
i_vs  in  1  vertical sync, active-low
i_rgb  in  8  {R[2:0],G[2:0],B[1:0]}
o_x  out  10  active pixel column 0..639
o_y  out  9  active line 0..479
o_de  out  1  pixel valid (locked and in active area)
o_pix  out  8  registered i_rgb when o_de, else 0
o_locked  out  1  timing lock
o_frame_stb  out  1  1-clk pulse at each VS fall while locked
o_err  out  1  1-clk pulse on any timing violation
o_crc  out  16  per-frame pixel CRC (see Optional Feature)

Behaviour:
- Reset (i_rst=0 at a clock edge): all outputs 0, state SEARCH, counters 0, edge history hs_q/vs_q=1.
- Edge detection: a fall is a strobe sample of 0 with the previous strobe sample 1.
- h_cnt (11b): on HS fall becomes 0, otherwise +1 per strobe, saturating at 2047.
- v_cnt (10b): on VS fall set vs_pend. On HS fall, if vs_pend then v_cnt=0 and clear vs_pend; else v_cnt+1, saturating at 1023.
- Active area: h_cnt in [H_SYNC+H_BP, +H_ACTIVE) = [144,784) and v_cnt in [V_SYNC+V_BP, +V_ACTIVE) = [35,515).
  - o_x = h_cnt-144; o_y = v_cnt-35.
  - o_x/o_y hold their last value outside the active area.
- Latency: outputs are registered on the same edge as the strobe sample, i.e. 1 i_clk after the input is sampled. Outputs hold between strobes.
- FSM:
  - SEARCH → TRACK on VS fall. good_cnt=0. The line-length check is disabled until the next HS fall.
  - TRACK: at each HS fall, check h_cnt+1==H_TOTAL. At each VS fall, check v_cnt+1==V_TOTAL. A frame with no failures increments good_cnt. When good_cnt reaches LOCK_FRAMES, go to LOCKED and set o_locked=1.
  - LOCKED: same checks. o_frame_stb pulses on each VS fall.
  - Any failed check in TRACK or LOCKED: pulse o_err, clear o_locked, return to SEARCH.
  - h_cnt reaching 2*H_TOTAL (HS stuck): also pulse o_err and return to SEARCH.
- Simultaneous HS fall and VS fall on one strobe: process the VS fall first (set vs_pend), then the HS fall consumes it, so v_cnt=0.
- o_de=1 only in LOCKED and inside the active area. The pixel on the same strobe that loses lock is not marked valid.
- Reset mid-frame: immediate return to reset values. Lock requires a full LOCK_FRAMES again.

Optional Feature:
Macro FRAME_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over o_pix for every o_de pixel.
  - o_crc is latched on the clock o_frame_stb pulses; the running CRC then re-inits to 0xFFFF.
  - The running CRC also re-inits when entering LOCKED.
- Undefined: o_crc is constant 0 and no CRC logic is built.

Test Plan:
- Reset held low 5 clks with toggling inputs → all outputs 0. Release and drive standard 640x480 timing → o_locked rises at the VS fall ending frame 3 (1st VS fall enters TRACK, 2 good frames), and o_err never pulses.
- Locked, i_rgb=8'hE0 for tx pixel (0,0) → exactly one strobe with o_de=1, o_x=0, o_y=0, o_pix=8'hE0. Last active strobe shows o_x=639, o_y=479. Exactly 307200 o_de strobes per frame.
- Locked, one line shortened to 799 pixels → o_err pulse at that HS fall, o_locked=0 next clk, relock after 2 further good frames.
- Locked, frame with 524 lines → o_err at VS fall, SEARCH. HS held high 1600 strobes → o_err and SEARCH.
- Coincident HS and VS fall injected → v_cnt=0 at that edge and the following active area starts at o_y=0 after 35 lines.
- FRAME_CRC_EN: constant i_rgb=8'h00 for a full frame → o_crc equals the golden model value at o_frame_stb, identical for consecutive frames. Undefined: o_crc stays 16'h0000.
